// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst SRAM responder.
package wb_burst_pkg;
  localparam int DATA_W     = 32;
  localparam int BL_W       = 10;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;
endpackage

// File: rtl/wb_burst_skid_fifo.sv
// Read-return skid FIFO: synchronous, power-of-2 depth, flush, simultaneous push+pop when full.
module wb_burst_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_burst_sram_slave.sv
// Wishbone burst slave serving line refills and write-backs from a 1-cycle-latency
// single-port SRAM; reads stream through a credit-limited skid FIFO.
module wb_burst_sram_slave #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int BL_W       = 10,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic [BL_W-1:0]   wbs_bl_i,
  input  logic              wbs_bry_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [DATA_W-1:0] sram_din0_o,
  input  logic [DATA_W-1:0] sram_dout0_i
);
  import wb_burst_pkg::*;

  localparam int CW  = BL_W + 1;
  localparam int FCW = $clog2(SKID_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     n_beats;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     acked;
  logic [3:0]        sel_q;
  logic              inflight;
  logic              issue;
  logic              last_ack;
  logic [31:0]       occ;

  logic              fifo_flush;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic              unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[31:ADDR_W+WORD_SHIFT], wbs_adr_i[WORD_SHIFT-1:0]};
  assign fifo_flush = (state == RD) && !wbs_cyc_i;
  assign last_ack   = ((acked + CW'(1)) == n_beats);

  wb_burst_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (wb_rst_i),
    .flush     (fifo_flush),
    .push      (inflight),
    .push_data (sram_dout0_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full_unused)
  );

  // Handshake and SRAM drive are combinational so a write beat lands in the same cycle it is acked.
  always_comb begin
    wbs_ack_o     = 1'b0;
    wbs_dat_o     = '0;
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    fifo_pop      = 1'b0;
    issue         = 1'b0;
    occ           = '0;
    if (!wb_rst_i) begin
      case (state)
        RD: begin
          fifo_pop  = !fifo_empty && wbs_bry_i && wbs_cyc_i;
          wbs_ack_o = fifo_pop;
          if (fifo_pop) begin
            wbs_dat_o = fifo_head;
          end
          // A read may issue only if its data is guaranteed a FIFO slot on return.
          occ = 32'(fifo_count) + 32'(inflight) + 32'(!fifo_pop);
          if (wbs_cyc_i && (issued < n_beats) && (occ <= 32'(SKID_DEPTH))) begin
            issue        = 1'b1;
            sram_csb0_o  = 1'b0;
            sram_addr0_o = ptr;
          end
        end
        WR: begin
          wbs_ack_o = wbs_bry_i && wbs_cyc_i && wbs_stb_i;
          if (wbs_ack_o) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = 1'b0;
            sram_wmask0_o = sel_q;
            sram_din0_o   = wbs_dat_i;
            sram_addr0_o  = ptr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      n_beats  <= '0;
      issued   <= '0;
      acked    <= '0;
      sel_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            ptr     <= wbs_adr_i[WORD_SHIFT +: ADDR_W];
            n_beats <= (wbs_bl_i == '0) ? CW'(1) : {1'b0, wbs_bl_i};
            sel_q   <= wbs_sel_i;
            issued  <= '0;
            acked   <= '0;
            state   <= wbs_we_i ? WR : RD;
          end
        end
        RD: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            if (issue) begin
              ptr    <= ptr + 1'b1;
              issued <= issued + CW'(1);
            end
            if (wbs_ack_o) begin
              acked <= acked + CW'(1);
              if (last_ack) begin
                state <= DONE;
              end
            end
          end
        end
        WR: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (wbs_ack_o) begin
            ptr   <= ptr + 1'b1;
            acked <= acked + CW'(1);
            if (last_ack) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!wbs_stb_i || !wbs_cyc_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_sram_slave.sv
// Directed bench for wb_burst_sram_slave with a behavioural 1-cycle SRAM.
module tb_wb_burst_sram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, bry = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [9:0]  bl = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [7:0]  saddr;
  logic [31:0] sdin, sdout;

  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_q [$];

  always #5 clk = ~clk;

  wb_burst_sram_slave #(.DATA_W(32), .ADDR_W(8), .BL_W(10), .SKID_DEPTH(4)) dut (
    .clk(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_bl_i(bl), .wbs_bry_i(bry),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .sram_csb0_o(csb), .sram_web0_o(web),
    .sram_wmask0_o(wmask), .sram_addr0_o(saddr), .sram_din0_o(sdin), .sram_dout0_i(sdout)
  );

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] = bd_data;
    end else if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][8*b +: 8] = sdin[8*b +: 8];
      end else begin
        sdout <= mem[saddr];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [9:0] b, input logic [3:0] se,
                       input logic br, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b0; rst = r; cyc = c; stb = s; we = w; adr = a; bl = b; sel = se; bry = br; dat_i = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
  endtask

  // mode 0: bry always 1; mode 1: bry 1,0,0 repeating; mode 2: bry 0 for 12 cycles then 1.
  task automatic rd_burst(input logic [31:0] a, input logic [9:0] b, input int mode,
                          input int abort_after, output int nacks, output int first_idx,
                          output int last_idx, output int bad, output int stall_issues,
                          output logic end_ack, output logic end_csb);
    int want;
    logic br;
    want = (b == 0) ? 1 : int'(b);
    if (abort_after > 0) want = abort_after;
    rd_q.delete();
    nacks = 0; first_idx = -1; last_idx = -1; bad = 0; stall_issues = 0;
    for (int idx = 0; idx < 200 && nacks < want; idx++) begin
      br = (mode == 0) ? 1'b1 : (mode == 1) ? ((idx % 3) == 0) : (idx >= 12);
      drive(1'b0, 1'b1, 1'b1, 1'b0, a, b, 4'h0, br, 32'h0);
      if (ack && !br) bad++;
      if (!csb && idx < 12) stall_issues++;
      if (ack) begin
        if (first_idx < 0) first_idx = idx;
        last_idx = idx;
        rd_q.push_back(dat_o);
        nacks++;
      end
    end
    idle();
    end_ack = ack;
    end_csb = csb;
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [9:0] b, input logic [3:0] s,
                          input logic [31:0] d0, output int nacks, output int first_idx);
    int want;
    want = (b == 0) ? 1 : int'(b);
    nacks = 0; first_idx = -1;
    for (int idx = 0; idx < 200 && nacks < want; idx++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, a, b, s, 1'b1, d0 + 32'(nacks));
      if (ack) begin
        if (first_idx < 0) first_idx = idx;
        nacks++;
      end
    end
    idle();
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [9:0]  bl;
    logic [3:0]  sel;
    logic [31:0] d0;
    int          beats;
    logic [31:0] e0;
    logic [31:0] einc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n, f, l, bad, si, viol;
    logic ea, ec;

    vecs[0] = '{1'b1, 32'h0000_03F8, 10'd4, 4'hF, 32'h0000_0001, 4, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_03F8, 10'd4, 4'h0, 32'h0, 4, 32'h0000_0001, 32'h1};
    vecs[2] = '{1'b0, 32'h0000_0000, 10'd2, 4'h0, 32'h0, 2, 32'h0000_0003, 32'h1};
    vecs[3] = '{1'b1, 32'h0000_0084, 10'd1, 4'b0011, 32'hDEAD_BEEF, 1, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0084, 10'd1, 4'h0, 32'h0, 1, 32'h1111_BEEF, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0087, 10'd0, 4'b1100, 32'hCAFE_0000, 1, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0084, 10'd0, 4'h0, 32'h0, 1, 32'hCAFE_BEEF, 32'h0};
    vecs[7] = '{1'b0, 32'hFFFF_FC84, 10'd1, 4'h0, 32'h0, 1, 32'hCAFE_BEEF, 32'h0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 1'b0, 32'h0);
    idle();
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_csb", csb, 1);
    chk("rst_web", web, 1);
    chk("rst_wmask", wmask, 0);
    chk("rst_addr", saddr, 0);
    chk("rst_din", sdin, 0);

    for (int i = 0; i < 8; i++) poke(8'h10 + 8'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 16; i++) poke(8'h40 + 8'(i), 32'hB000 + 32'(i));
    poke(8'h60, 32'hC0); poke(8'h61, 32'hC1);
    poke(8'h21, 32'h1111_1111);
    for (int i = 0; i < 3; i++) poke(8'h80 + 8'(i), 32'h5555_5555);
    poke(8'hC2, 32'h1234_5678);

    // Straight 8-beat read: latency and back-to-back beats
    rd_burst(32'h40, 10'd8, 0, 0, n, f, l, bad, si, ea, ec);
    chk("t1_beats", n, 8);
    chk("t1_first_ack", f, 3);
    chk("t1_last_ack", l, 10);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_dat%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hx, 32'hA0 + 32'(i));

    // Throttled read
    rd_burst(32'h40, 10'd8, 1, 0, n, f, l, bad, si, ea, ec);
    chk("t2_beats", n, 8);
    chk("t2_ack_while_bry0", bad, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_dat%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hx, 32'hA0 + 32'(i));

    // Long stall: issues stop at FIFO credit, no data lost
    rd_burst(32'h40, 10'd8, 2, 0, n, f, l, bad, si, ea, ec);
    chk("t2s_beats", n, 8);
    chk("t2s_stall_issues", si, 4);
    chk("t2s_ack_while_bry0", bad, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2s_dat%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hx, 32'hA0 + 32'(i));

    // Table: wrap writes, byte-masked write, bl=0, ignored address bits
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].we) begin
        wr_burst(vecs[v].adr, vecs[v].bl, vecs[v].sel, vecs[v].d0, n, f);
        chk($sformatf("vec%0d_wbeats", v), n, vecs[v].beats);
        chk($sformatf("vec%0d_wfirst", v), f, 1);
      end else begin
        rd_burst(vecs[v].adr, vecs[v].bl, 0, 0, n, f, l, bad, si, ea, ec);
        chk($sformatf("vec%0d_rbeats", v), n, vecs[v].beats);
        for (int i = 0; i < vecs[v].beats; i++)
          chk($sformatf("vec%0d_dat%0d", v, i), (i < rd_q.size()) ? rd_q[i] : 32'hx,
              vecs[v].e0 + 32'(i) * vecs[v].einc);
      end
    end
    chk("t3_mem_fe", mem[8'hFE], 32'h1);
    chk("t3_mem_ff", mem[8'hFF], 32'h2);
    chk("t3_mem_00", mem[8'h00], 32'h3);
    chk("t3_mem_01", mem[8'h01], 32'h4);

    // Abort a 16-beat read after 5 beats, then a fresh read
    rd_burst(32'h100, 10'd16, 0, 5, n, f, l, bad, si, ea, ec);
    chk("t5_beats", n, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t5_dat%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hx, 32'hB000 + 32'(i));
    chk("t5_abort_ack", ea, 0);
    chk("t5_abort_csb", ec, 1);
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (ack || !csb) viol++;
    end
    chk("t5_quiet_after_abort", viol, 0);
    rd_burst(32'h180, 10'd2, 0, 0, n, f, l, bad, si, ea, ec);
    chk("t5_new_beats", n, 2);
    chk("t5_new_dat0", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'hC0);
    chk("t5_new_dat1", (rd_q.size() > 1) ? rd_q[1] : 32'hx, 32'hC1);

    // Reset in the middle of a 4-beat write
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 10'd4, 4'hF, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 10'd4, 4'hF, 1'b1, 32'h600);
    chk("t6_ack_beat0", ack, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 10'd4, 4'hF, 1'b1, 32'h601);
    chk("t6_ack_beat1", ack, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 10'd4, 4'hF, 1'b0, 32'h602);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 10'd4, 4'hF, 1'b1, 32'h602);
    chk("t6_post_rst_ack", ack, 0);
    chk("t6_post_rst_dat", dat_o, 0);
    chk("t6_post_rst_csb", csb, 1);
    chk("t6_post_rst_web", web, 1);
    chk("t6_post_rst_wmask", wmask, 0);
    chk("t6_post_rst_addr", saddr, 0);
    chk("t6_post_rst_din", sdin, 0);
    idle();
    idle();
    chk("t6_mem_80", mem[8'h80], 32'h600);
    chk("t6_mem_81", mem[8'h81], 32'h601);
    chk("t6_mem_82", mem[8'h82], 32'h5555_5555);

    // Strobe held after the last beat must not start another burst
    n = 0; viol = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 10'd2, 4'hF, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 10'd2, 4'hF, 1'b1, 32'h700);
    if (ack) n++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 10'd2, 4'hF, 1'b1, 32'h701);
    if (ack) n++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 10'd2, 4'hF, 1'b1, 32'h7FF);
      if (ack || !csb) viol++;
    end
    idle();
    idle();
    chk("t6h_beats", n, 2);
    chk("t6h_held_stb_quiet", viol, 0);
    chk("t6h_mem_c0", mem[8'hC0], 32'h700);
    chk("t6h_mem_c1", mem[8'hC1], 32'h701);
    chk("t6h_mem_c2", mem[8'hC2], 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
